multicycle_ctrl: RTL

Control unit for the multicycle ARM-subset datapath. It decodes instruction fields, sequences each instruction through a Moore state machine, and holds the NZCV flag register. It also drives `ALUControl`/`special` into the ALU and consumes the `ALUFlags` it returns. It sits between the instruction register and the datapath muxes/enables, one instance per core.

---
 rtl/arch_pkg.sv | 85 ++++++++
 rtl/cond_check.sv | 35 +++
 rtl/multicycle_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/arch_pkg.sv
// rtl/arch_pkg.sv - shared encodings and instruction decode for multicycle_ctrl
// LONGMUL_EN adds SMUL/UMUL decode and the ALUWB_HI state.
package arch_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
`ifdef LONGMUL_EN
    , ALUWB_HI
`endif
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_ORR  = 3'b011;
  localparam logic [2:0] ALU_EOR  = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_SMUL = 3'b110;
  localparam logic [2:0] ALU_UMUL = 3'b111;
  localparam logic [2:0] ALU_DIV  = 3'b100;

  localparam logic [3:0] CMD_AND  = 4'b0000;
  localparam logic [3:0] CMD_EOR  = 4'b0001;
  localparam logic [3:0] CMD_SUB  = 4'b0010;
  localparam logic [3:0] CMD_ADD  = 4'b0100;
  localparam logic [3:0] CMD_CMP  = 4'b1010;
  localparam logic [3:0] CMD_ORR  = 4'b1100;
  localparam logic [3:0] CMD_MUL  = 4'b0000;
  localparam logic [3:0] CMD_SMUL = 4'b0110;
  localparam logic [3:0] CMD_UMUL = 4'b0100;
  localparam logic [3:0] CMD_DIV  = 4'b1000;

  localparam logic [3:0] MULOP_SPECIAL = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE;

  typedef struct packed {
    logic [2:0] alu;
    logic       special;
    logic       wr;
    logic       setf;
    logic       upd_cv;
`ifdef LONGMUL_EN
    logic       long_mul;
`endif
  } dec_t;

  function automatic dec_t decode(input logic [1:0] op, input logic [5:0] funct,
                                  input logic [3:0] mulop);
    dec_t d;
    d      = '0;
    d.alu  = ALU_ADD;
    d.wr   = 1'b1;
    d.setf = funct[0];
    if (op == 2'b00 && !funct[5] && mulop == MULOP_SPECIAL) begin
      d.special = 1'b1;
      case (funct[4:1])
        CMD_MUL: d.alu = ALU_MUL;
`ifdef LONGMUL_EN
        CMD_SMUL: begin d.alu = ALU_SMUL; d.long_mul = 1'b1; end
        CMD_UMUL: begin d.alu = ALU_UMUL; d.long_mul = 1'b1; end
`else
        CMD_SMUL, CMD_UMUL: d.alu = ALU_MUL;
`endif
        CMD_DIV: d.alu = ALU_DIV;
        default: begin d.special = 1'b0; d.wr = 1'b0; d.upd_cv = 1'b1; end
      endcase
    end else begin
      case (funct[4:1])
        CMD_ADD: begin d.alu = ALU_ADD; d.upd_cv = 1'b1; end
        CMD_SUB: begin d.alu = ALU_SUB; d.upd_cv = 1'b1; end
        CMD_AND: d.alu = ALU_AND;
        CMD_ORR: d.alu = ALU_ORR;
        CMD_EOR: d.alu = ALU_EOR;
        CMD_CMP: begin d.alu = ALU_SUB; d.wr = 1'b0; d.setf = 1'b1; d.upd_cv = 1'b1; end
        default: begin d.wr = 1'b0; d.upd_cv = 1'b1; end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - ARM condition-code evaluation against NZCV flags
module cond_check
  import arch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z && (n == v);
      COND_LE: cond_ex = z || (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;  // 4'b1111 never executes
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle ARM-subset control FSM with NZCV flag register
// LONGMUL_EN enables SMUL/UMUL and the RdHi write-back state.
module multicycle_ctrl
  import arch_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] MulOp,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [2:0] ALUControl,
  output logic       special,
  output logic       LongHi,
  output logic [3:0] Flags
);

  state_t     state, next;
  dec_t       dec_q;
  logic [3:0] flags_q;
  logic       cond_ex;
  logic       in_exec;

  cond_check u_cond_check (.cond(Cond), .flags(flags_q), .cond_ex(cond_ex));

  assign in_exec = (state == EXECR) || (state == EXECI);
  assign Flags   = flags_q;
  assign ImmSrc  = Op;
  assign RegSrc  = {Op == 2'b01, Op == 2'b10};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FETCH;
      dec_q   <= '0;
      flags_q <= 4'b0000;
    end else begin
      state <= next;
      if (state == DECODE) dec_q <= decode(Op, Funct, MulOp);
      // EXEC is only reachable with CondEx=1, so no re-check here
      if (in_exec && dec_q.setf) begin
        flags_q[3:2] <= ALUFlags[3:2];
        if (dec_q.upd_cv) flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    next       = FETCH;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    ResultSrc  = 2'd0;
    ALUControl = ALU_ADD;
    special    = 1'b0;
    LongHi     = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 2'd1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
        next      = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        if (cond_ex) begin
          case (Op)
            2'b01:   next = MEMADR;
            2'b10:   next = BRANCH;
            2'b00:   next = Funct[5] ? EXECI : EXECR;
            default: next = FETCH;
          endcase
        end
      end
      MEMADR: begin
        ALUSrcB = 2'd1;
        next    = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        next   = MEMWB;
      end
      MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'd1;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = 2'd1;
        ResultSrc = 2'd2;
        PCWrite   = 1'b1;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (state == EXECI) ? 2'd1 : 2'd0;
        ALUControl = dec_q.alu;
        special    = dec_q.special;
        next       = dec_q.wr ? ALUWB : FETCH;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        ALUControl = dec_q.alu;
        special    = dec_q.special;
`ifdef LONGMUL_EN
        next       = dec_q.long_mul ? ALUWB_HI : FETCH;
`endif
      end
`ifdef LONGMUL_EN
      ALUWB_HI: begin
        RegWrite   = 1'b1;
        LongHi     = 1'b1;
        ALUControl = dec_q.alu;
        special    = dec_q.special;
      end
`endif
      default: next = FETCH;
    endcase
  end

endmodule
